// File: rtl/mem_access_ctrl_if.sv
// Control-unit / memory bus bundle for mem_access_ctrl.
// master = control unit plus memory model side, slave = the sequencer.
interface mem_access_ctrl_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              busy;
    logic              done;
    logic              err;
    logic [DATA_W-1:0] rdata;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_rd;
    logic              mem_wr;
    logic              mem_ready;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output req, we, addr, wdata, mem_ready, mem_rdata,
        input  busy, done, err, rdata, mem_addr, mem_wdata, mem_rd, mem_wr
    );

    modport slave (
        input  req, we, addr, wdata, mem_ready, mem_rdata,
        output busy, done, err, rdata, mem_addr, mem_wdata, mem_rd, mem_wr
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// Multi-cycle single-word memory access sequencer (IDLE/SETUP/ACCESS/DONE).
// Optional misaligned-address rejection is enabled by defining MEM_ALIGN_CHECK_EN.
module mem_access_ctrl #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 15
) (
    input logic              clk,
    input logic              rst,
    mem_access_ctrl_if.slave bus
);
    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

    state_t            state;
    logic              we_q;
    logic [CNT_W-1:0]  cnt;
    logic              busy_q, done_q, err_q, mem_rd_q, mem_wr_q;
    logic [DATA_W-1:0] rdata_q, mem_wdata_q;
    logic [ADDR_W-1:0] mem_addr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            we_q        <= 1'b0;
            cnt         <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            mem_rd_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            rdata_q     <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            // done/err are one-cycle pulses; only the DONE entry sets them
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.req) begin
                        mem_addr_q  <= bus.addr;
                        mem_wdata_q <= bus.wdata;
                        we_q        <= bus.we;
                        cnt         <= '0;
                        busy_q      <= 1'b1;
`ifdef MEM_ALIGN_CHECK_EN
                        if (bus.addr[1:0] != 2'b00) begin
                            state  <= DONE;
                            done_q <= 1'b1;
                            err_q  <= 1'b1;
                        end else begin
                            state <= SETUP;
                        end
`else
                        state <= SETUP;
`endif
                    end
                end
                SETUP: begin
                    state    <= ACCESS;
                    mem_rd_q <= ~we_q;
                    mem_wr_q <= we_q;
                end
                ACCESS: begin
                    if (cnt != '1) cnt <= cnt + 1'b1;
                    // ready wins over a timeout landing on the same cycle
                    if (bus.mem_ready) begin
                        if (!we_q) rdata_q <= bus.mem_rdata;
                        mem_rd_q <= 1'b0;
                        mem_wr_q <= 1'b0;
                        state    <= DONE;
                        done_q   <= 1'b1;
                    end else if (TIMEOUT != 0 && cnt == CNT_LAST) begin
                        mem_rd_q <= 1'b0;
                        mem_wr_q <= 1'b0;
                        state    <= DONE;
                        done_q   <= 1'b1;
                        err_q    <= 1'b1;
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                    cnt    <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
    assign bus.rdata     = rdata_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_rd    = mem_rd_q;
    assign bus.mem_wr    = mem_wr_q;
endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed table-driven bench for mem_access_ctrl (TIMEOUT=4), plus reset and
// alignment sequences; behaviour with MEM_ALIGN_CHECK_EN follows the same macro.
module tb_mem_access_ctrl;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    mem_access_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    mem_access_ctrl #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          we;
        logic [31:0]   addr;
        logic [31:0]   wdata;
        logic [31:0]   mrdata;
        int            waits;     // ACCESS cycles with mem_ready=0 before ready
        int            inject;    // sample index at which a stray req is pulsed (0 = none)
        int            exp_cyc;   // samples from accept to done
        logic          exp_err;
        logic [31:0]   exp_rdata;
        int            exp_strb;  // cycles the strobe is high
    } vec_t;

    vec_t vecs[8];
    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic run_access(input string nm, input vec_t v);
        int   cyc, strb;
        logic bad, got_done, err_s, extra;
        cyc = 0; strb = 0; bad = 1'b0; got_done = 1'b0; err_s = 1'b0; extra = 1'b0;
        bus.mem_ready = 1'b0;
        bus.mem_rdata = v.mrdata;
        bus.req   = 1'b1;
        bus.we    = v.we;
        bus.addr  = v.addr;
        bus.wdata = v.wdata;
        tick;
        // scramble request inputs to prove they were latched
        bus.req   = 1'b0;
        bus.we    = ~v.we;
        bus.addr  = 32'hFFFF_FFF0;
        bus.wdata = 32'h0;
        for (int i = 0; i < 30 && !got_done; i++) begin
            cyc++;
            if (cyc == 1) chk({nm, ".busy"}, {31'b0, bus.busy}, 32'd1);
            if (bus.mem_rd && bus.mem_wr) bad = 1'b1;
            if ((bus.mem_rd && v.we) || (bus.mem_wr && !v.we)) bad = 1'b1;
            if (bus.mem_rd || bus.mem_wr) strb++;
            if (bus.done) begin
                got_done = 1'b1;
                err_s    = bus.err;
            end
            bus.req = (cyc == v.inject);
            if (cyc == v.inject) bus.addr = 32'hC0;
            bus.mem_ready = (bus.mem_rd || bus.mem_wr) && (strb > v.waits);
            if (!got_done) tick;
        end
        chk({nm, ".done_seen"}, {31'b0, got_done}, 32'd1);
        chk({nm, ".latency"},   cyc,               v.exp_cyc);
        chk({nm, ".err"},       {31'b0, err_s},    {31'b0, v.exp_err});
        chk({nm, ".rdata"},     bus.rdata,         v.exp_rdata);
        chk({nm, ".strobe_cyc"}, strb,             v.exp_strb);
        chk({nm, ".strobe_ok"}, {31'b0, bad},      32'd0);
        chk({nm, ".mem_addr"},  bus.mem_addr,      v.addr);
        chk({nm, ".mem_wdata"}, bus.mem_wdata,     v.wdata);
        for (int i = 0; i < 5; i++) begin
            tick;
            bus.req = 1'b0;
            bus.mem_ready = 1'b0;
            if (bus.done || bus.busy || bus.mem_rd || bus.mem_wr) extra = 1'b1;
        end
        chk({nm, ".idle_after"}, {31'b0, extra}, 32'd0);
        chk({nm, ".addr_hold"},  bus.mem_addr,   v.addr);
    endtask

    initial begin
        vec_t va;
        logic noisy;
        //          we  addr    wdata         mrdata        wt in cyc err rdata         strb
        vecs[0] = '{1'b0, 32'h40,  32'h0,        32'h1234ABCD, 0, 0, 3, 1'b0, 32'h1234ABCD, 1};
        vecs[1] = '{1'b1, 32'h80,  32'hDEADBEEF, 32'h0,        2, 0, 5, 1'b0, 32'h1234ABCD, 3};
        vecs[2] = '{1'b0, 32'h100, 32'h0,        32'h77777777, 99, 0, 6, 1'b1, 32'h1234ABCD, 4};
        vecs[3] = '{1'b0, 32'h104, 32'h0,        32'hCAFEF00D, 1, 0, 4, 1'b0, 32'hCAFEF00D, 2};
        vecs[4] = '{1'b1, 32'h108, 32'h0,        32'h0,        3, 0, 6, 1'b0, 32'hCAFEF00D, 4};
        vecs[5] = '{1'b0, 32'h10C, 32'h0,        32'h11111111, 4, 0, 6, 1'b1, 32'hCAFEF00D, 4};
        vecs[6] = '{1'b0, 32'h200, 32'h0,        32'h0BADF00D, 3, 3, 6, 1'b0, 32'h0BADF00D, 4};
        vecs[7] = '{1'b1, 32'h300, 32'h5A5A5A5A, 32'h0,        0, 3, 3, 1'b0, 32'h0BADF00D, 1};

        bus.req = 1'b0; bus.we = 1'b0; bus.addr = '0; bus.wdata = '0;
        bus.mem_ready = 1'b1; bus.mem_rdata = 32'hFFFFFFFF;
        rst = 1'b1;
        tick; tick;
        chk("rst.busy",      {31'b0, bus.busy},   32'd0);
        chk("rst.done",      {31'b0, bus.done},   32'd0);
        chk("rst.err",       {31'b0, bus.err},    32'd0);
        chk("rst.rdata",     bus.rdata,           32'd0);
        chk("rst.mem_addr",  bus.mem_addr,        32'd0);
        chk("rst.mem_wdata", bus.mem_wdata,       32'd0);
        chk("rst.strobes",   {30'b0, bus.mem_rd, bus.mem_wr}, 32'd0);
        rst = 1'b0;
        // mem_ready high in IDLE must not do anything
        tick; tick;
        chk("idle.ready_ignored", {30'b0, bus.busy, bus.done}, 32'd0);

        for (int k = 0; k < 8; k++) run_access($sformatf("vec%0d", k), vecs[k]);

        // reset during the second ACCESS cycle
        bus.mem_ready = 1'b0;
        bus.req = 1'b1; bus.we = 1'b0; bus.addr = 32'h400; bus.wdata = 32'h0;
        tick;
        bus.req = 1'b0;
        tick;
        chk("midrst.access1_rd", {31'b0, bus.mem_rd}, 32'd1);
        tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        chk("midrst.mem_rd", {31'b0, bus.mem_rd}, 32'd0);
        chk("midrst.busy",   {31'b0, bus.busy},   32'd0);
        chk("midrst.rdata",  bus.rdata,           32'd0);
        noisy = bus.done;
        for (int i = 0; i < 4; i++) begin
            tick;
            if (bus.done || bus.busy) noisy = 1'b1;
        end
        chk("midrst.no_done", {31'b0, noisy}, 32'd0);
        va = '{1'b0, 32'h44, 32'h0, 32'h55AA55AA, 0, 0, 3, 1'b0, 32'h55AA55AA, 1};
        run_access("post_rst", va);

`ifdef MEM_ALIGN_CHECK_EN
        va = '{1'b0, 32'h42, 32'h0, 32'h13579BDF, 0, 0, 1, 1'b1, 32'h55AA55AA, 0};
`else
        va = '{1'b0, 32'h42, 32'h0, 32'h13579BDF, 0, 0, 3, 1'b0, 32'h13579BDF, 1};
`endif
        run_access("misalign", va);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
